// File: rtl/regdst_hazard_pipe.sv
// Decode-stage destination select plus a DEPTH-stage destination/Tnew tracker
// that derives the D-stage stall request and per-operand forwarding selects.
module regdst_hazard_pipe #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int TNEW_W   = 2,
    parameter int LINK_REG = 31,
    parameter int SEL_W    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [3:0]                 d_regdst,
    input  logic [ADDR_W-1:0]          d_a2,
    input  logic [ADDR_W-1:0]          d_a3,
    input  logic                       d_cond,
    input  logic [TNEW_W-1:0]          d_tnew,
    input  logic [ADDR_W-1:0]          d_rs,
    input  logic [ADDR_W-1:0]          d_rt,
    input  logic                       d_use_rs,
    input  logic                       d_use_rt,
    input  logic [TNEW_W-1:0]          d_tuse_rs,
    input  logic [TNEW_W-1:0]          d_tuse_rt,
    output logic [ADDR_W-1:0]          d_dst,
    output logic                       stall,
    output logic [SEL_W-1:0]           fwd_rs_sel,
    output logic [SEL_W-1:0]           fwd_rt_sel,
    output logic [DEPTH*ADDR_W-1:0]    stage_dst,
    output logic [DEPTH*TNEW_W-1:0]    stage_tnew
);

    typedef struct packed {
        logic             stall;
        logic [SEL_W-1:0] sel;
    } hazard_t;

    // Index k-1 holds stage k, so the packed arrays flatten directly onto the ports.
    logic [DEPTH-1:0][ADDR_W-1:0] dst_q;
    logic [DEPTH-1:0][TNEW_W-1:0] tnew_q;

    hazard_t haz_rs;
    hazard_t haz_rt;

    // NOTE: every combinational output gets a default before the case, so no
    // encoding can leave d_dst unassigned and infer a latch.
    always_comb begin
        d_dst = '0;
        case (d_regdst)
            4'd1:    d_dst = ADDR_W'(LINK_REG);
            4'd2:    d_dst = d_a2;
            4'd3:    d_dst = d_a3;
            4'd4:    d_dst = d_cond ? d_a3 : '0;
            default: d_dst = '0;
        endcase
    end

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // Youngest matching stage wins; $0 and unused operands never match.
    function automatic hazard_t resolve(
        input logic [DEPTH-1:0][ADDR_W-1:0] dst,
        input logic [DEPTH-1:0][TNEW_W-1:0] tnew,
        input logic [ADDR_W-1:0]            src,
        input logic                         use_src,
        input logic [TNEW_W-1:0]            tuse
    );
        hazard_t r;
        logic    found;
        r     = '0;
        found = 1'b0;
        if (use_src && src != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && dst[k] == src) begin
                    found   = 1'b1;
                    r.stall = tnew[k] > tuse;
                    r.sel   = (tnew[k] == '0) ? SEL_W'(k + 1) : '0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        haz_rs = resolve(dst_q, tnew_q, d_rs, d_use_rs, d_tuse_rs);
        haz_rt = resolve(dst_q, tnew_q, d_rt, d_use_rt, d_tuse_rt);
    end

    assign stall      = haz_rs.stall | haz_rt.stall;
    assign fwd_rs_sel = haz_rs.sel;
    assign fwd_rt_sel = haz_rt.sel;
    assign stage_dst  = dst_q;
    assign stage_tnew = tnew_q;

    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // pre-edge value, which is what makes the loop a shift register.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            dst_q  <= '0;
            tnew_q <= '0;
        end else begin
            dst_q[0]  <= stall ? '0 : d_dst;
            tnew_q[0] <= stall ? '0 : d_tnew;
            for (int k = 1; k < DEPTH; k++) begin
                dst_q[k]  <= dst_q[k-1];
                tnew_q[k] <= sat_dec(tnew_q[k-1]);
            end
        end
    end

endmodule

// File: tb/tb_regdst_hazard_pipe.sv
// Directed self-checking bench for regdst_hazard_pipe with the default
// parameters (ADDR_W=5, DEPTH=3, TNEW_W=2, LINK_REG=31, SEL_W=2).
module tb_regdst_hazard_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [3:0]  d_regdst;
    logic [4:0]  d_a2;
    logic [4:0]  d_a3;
    logic        d_cond;
    logic [1:0]  d_tnew;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic        d_use_rs;
    logic        d_use_rt;
    logic [1:0]  d_tuse_rs;
    logic [1:0]  d_tuse_rt;
    logic [4:0]  d_dst;
    logic        stall;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic [14:0] stage_dst;
    logic [5:0]  stage_tnew;

    int checks   = 0;
    int failures = 0;

    regdst_hazard_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .d_regdst   (d_regdst),
        .d_a2       (d_a2),
        .d_a3       (d_a3),
        .d_cond     (d_cond),
        .d_tnew     (d_tnew),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_use_rs   (d_use_rs),
        .d_use_rt   (d_use_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_dst      (d_dst),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .stage_dst  (stage_dst),
        .stage_tnew (stage_tnew)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks run 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        d_regdst  = 4'd0;
        d_a2      = 5'd0;
        d_a3      = 5'd0;
        d_cond    = 1'b0;
        d_tnew    = 2'd0;
        d_rs      = 5'd0;
        d_rt      = 5'd0;
        d_use_rs  = 1'b0;
        d_use_rt  = 1'b0;
        d_tuse_rs = 2'd0;
        d_tuse_rt = 2'd0;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_dst"},   32'(stage_dst),  0);
        check({tag, "_tnew"},  32'(stage_tnew), 0);
        check({tag, "_stall"}, 32'(stall),      0);
        check({tag, "_fwdrs"}, 32'(fwd_rs_sel), 0);
        check({tag, "_fwdrt"}, 32'(fwd_rt_sel), 0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Reset, then one idle cycle.
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_empty("reset");

        // Link mode travels through all three stages; rs=31 forwards from each.
        d_regdst = 4'd1;
        d_tnew   = 2'd0;
        settle();
        check("link_d_dst", 32'(d_dst), 31);
        tick();
        d_regdst  = 4'd0;
        d_rs      = 5'd31;
        d_use_rs  = 1'b1;
        d_tuse_rs = 2'd0;
        settle();
        check("link_s1_dst", 32'(stage_dst[4:0]), 31);
        check("link_fwd1", 32'(fwd_rs_sel), 1);
        check("link_stall1", 32'(stall), 0);
        tick();
        check("link_s2_dst", 32'(stage_dst[9:5]), 31);
        check("link_s1_clear", 32'(stage_dst[4:0]), 0);
        check("link_fwd2", 32'(fwd_rs_sel), 2);
        tick();
        check("link_s3_dst", 32'(stage_dst[14:10]), 31);
        check("link_fwd3", 32'(fwd_rs_sel), 3);
        idle_inputs();
        tick();
        check_empty("link_drain");

        // Load-use: producer tnew=2, consumer tuse=0 stalls twice then forwards from W.
        d_regdst = 4'd2;
        d_a2     = 5'd8;
        d_tnew   = 2'd2;
        settle();
        check("lu_d_dst", 32'(d_dst), 8);
        tick();
        idle_inputs();
        d_rs      = 5'd8;
        d_use_rs  = 1'b1;
        d_tuse_rs = 2'd0;
        settle();
        check("lu_stall0", 32'(stall), 1);
        check("lu_fwd0", 32'(fwd_rs_sel), 0);
        tick();
        check("lu_s1_bubble", 32'(stage_dst[4:0]), 0);
        check("lu_s2", 32'({stage_dst[9:5], stage_tnew[3:2]}), 32'({5'd8, 2'd1}));
        check("lu_stall1", 32'(stall), 1);
        tick();
        check("lu_s3", 32'({stage_dst[14:10], stage_tnew[5:4]}), 32'({5'd8, 2'd0}));
        check("lu_stall2", 32'(stall), 0);
        check("lu_fwd3", 32'(fwd_rs_sel), 3);
        idle_inputs();
        tick();
        check_empty("lu_drain");

        // Youngest match wins: stage1={5,2}, stage3={5,0}.
        d_regdst = 4'd3;
        d_a3     = 5'd5;
        d_tnew   = 2'd0;
        tick();
        d_regdst = 4'd0;
        tick();
        d_regdst = 4'd3;
        d_tnew   = 2'd2;
        tick();
        idle_inputs();
        d_rt      = 5'd5;
        d_use_rt  = 1'b1;
        d_tuse_rt = 2'd1;
        settle();
        check("prio_dst", 32'(stage_dst), 32'({5'd5, 5'd0, 5'd5}));
        check("prio_tnew", 32'(stage_tnew), 32'({2'd0, 2'd0, 2'd2}));
        check("prio_stall", 32'(stall), 1);
        check("prio_fwd", 32'(fwd_rt_sel), 0);
        d_tuse_rt = 2'd2;
        settle();
        check("prio_tuse2_stall", 32'(stall), 0);
        check("prio_tuse2_fwd", 32'(fwd_rt_sel), 0);
        idle_inputs();
        tick();
        tick();
        tick();
        check_empty("prio_drain");

        // $0 is never tracked or matched; mode 4 and reserved modes.
        d_regdst = 4'd3;
        d_a3     = 5'd0;
        settle();
        check("zero_d_dst", 32'(d_dst), 0);
        tick();
        idle_inputs();
        d_rs      = 5'd0;
        d_use_rs  = 1'b1;
        d_tuse_rs = 2'd0;
        settle();
        check("zero_stall", 32'(stall), 0);
        check("zero_fwd", 32'(fwd_rs_sel), 0);
        idle_inputs();
        d_regdst = 4'd4;
        d_a3     = 5'd9;
        d_cond   = 1'b0;
        settle();
        check("m4_cond0", 32'(d_dst), 0);
        d_cond = 1'b1;
        settle();
        check("m4_cond1", 32'(d_dst), 9);
        d_regdst = 4'd7;
        settle();
        check("m7", 32'(d_dst), 0);
        d_regdst = 4'd15;
        settle();
        check("m15", 32'(d_dst), 0);
        idle_inputs();
        tick();

        // Flush during a stall clears every stage.
        d_regdst = 4'd3;
        d_a3     = 5'd7;
        d_tnew   = 2'd3;
        tick();
        d_regdst = 4'd2;
        d_a2     = 5'd8;
        d_tnew   = 2'd2;
        tick();
        idle_inputs();
        d_rs      = 5'd8;
        d_use_rs  = 1'b1;
        d_tuse_rs = 2'd0;
        settle();
        check("fl_pre_dst", 32'(stage_dst), 32'({5'd0, 5'd7, 5'd8}));
        check("fl_pre_stall", 32'(stall), 1);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        d_use_rs = 1'b0;
        settle();
        check_empty("flush");

        // Flush also wins over a new entry.
        d_regdst = 4'd1;
        flush    = 1'b1;
        tick();
        idle_inputs();
        check_empty("flush_entry");

        // Reset mid-stream with live D inputs and flush low.
        d_regdst = 4'd3;
        d_a3     = 5'd12;
        d_tnew   = 2'd3;
        tick();
        tick();
        check("rst_pre_dst", 32'(stage_dst), 32'({5'd0, 5'd12, 5'd12}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        d_rs      = 5'd12;
        d_use_rs  = 1'b1;
        d_tuse_rs = 2'd0;
        settle();
        check_empty("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
